// File: rtl/fixed_divider_if.sv
// Start/busy/done handshake and operand/result bundle between the solver control FSM and fixed_divider.
interface fixed_divider_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] o_quotient;
    logic             overflow_flag;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, o_quotient, overflow_flag, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, o_quotient, overflow_flag, div_zero
    );
endinterface

// File: rtl/fixed_divider.sv
// Signed Q(WIDTH-FRAC).FRAC restoring divider with saturation; done 27 edges after acceptance (26 without DIV_ROUND_EN), 2 on divide-by-zero.
// DIV_ROUND_EN adds a half-LSB guard bit for round-half-away-from-zero; start is ignored (not queued) unless IDLE.
module fixed_divider #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic              clk,
    input  logic              reset,
    fixed_divider_if.slave    bus
);
`ifdef DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NW  = WIDTH + FRAC + RND;
    localparam int ITW = $clog2(NW);
    localparam logic [ITW-1:0] LAST = ITW'(NW - 1);

    localparam logic [NW:0] LIM_POS = {{(NW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [NW:0] LIM_NEG = LIM_POS + 1'b1;
    localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       r_state;
    logic             r_sign;
    logic             r_nsign;
    logic             r_dz;
    logic [WIDTH-1:0] r_dvsr;
    logic [NW-1:0]    r_num;
    logic [WIDTH-1:0] r_rem;
    logic [ITW-1:0]   r_iter;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic             r_ovf;
    logic             r_dzo;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic [WIDTH:0]   w_rem_shift;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [NW:0]      w_q_mag;
    logic [WIDTH-1:0] w_q_lo;
    logic             w_ovf_pos;
    logic             w_ovf_neg;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) without overflow.
    always_comb begin
        w_a_mag  = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        w_b_mag  = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
        w_b_zero = (bus.divisor == '0);
    end

    always_comb begin
        w_rem_shift = {r_rem, r_num[NW-1]};
        w_qbit      = (w_rem_shift >= {1'b0, r_dvsr});
        w_rem_next  = w_qbit ? WIDTH'(w_rem_shift - {1'b0, r_dvsr}) : w_rem_shift[WIDTH-1:0];
    end

    always_comb begin
`ifdef DIV_ROUND_EN
        w_q_mag = {2'b00, r_num[NW-1:1]} + {{NW{1'b0}}, r_num[0]};
`else
        w_q_mag = {1'b0, r_num};
`endif
        w_q_lo    = w_q_mag[WIDTH-1:0];
        w_ovf_pos = !r_sign && (w_q_mag > LIM_POS);
        w_ovf_neg =  r_sign && (w_q_mag > LIM_NEG);
        w_ovf     = r_dz || w_ovf_pos || w_ovf_neg;
        if (r_dz) begin
            w_res = r_nsign ? Q_MIN : Q_MAX;
        end else if (w_ovf_pos) begin
            w_res = Q_MAX;
        end else if (w_ovf_neg) begin
            w_res = Q_MIN;
        end else begin
            w_res = r_sign ? (~w_q_lo + 1'b1) : w_q_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_nsign <= 1'b0;
            r_dz    <= 1'b0;
            r_dvsr  <= '0;
            r_num   <= '0;
            r_rem   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_ovf   <= 1'b0;
            r_dzo   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_nsign <= bus.dividend[WIDTH-1];
                        r_dz    <= w_b_zero;
                        r_dvsr  <= w_b_mag;
                        r_num   <= {{(NW - WIDTH){1'b0}}, w_a_mag} << (FRAC + RND);
                        r_rem   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= w_b_zero ? S_FINISH : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    // Numerator bits leave at the top while quotient bits fill in from the bottom.
                    r_rem  <= w_rem_next;
                    r_num  <= {r_num[NW-2:0], w_qbit};
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == LAST) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_quot  <= w_res;
                    r_ovf   <= w_ovf;
                    r_dzo   <= r_dz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_iter  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.o_quotient    = r_quot;
    assign bus.overflow_flag = r_ovf;
    assign bus.div_zero      = r_dzo;
endmodule

// File: tb/tb_fixed_divider.sv
// Bench for fixed_divider: arithmetic reference model plus per-cycle comparison, directed Q8.8 cases and random operands.
module tb_fixed_divider;
    localparam int W = 16;
    localparam int F = 8;
`ifdef DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fixed_divider_if #(.WIDTH(W)) dif ();
    fixed_divider #(.WIDTH(W), .FRAC(F)) dut (.clk(clk), .reset(reset), .bus(dif));

    int n_vec = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Returns {overflow, div_zero, quotient} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, ma, mb, raw, q, v;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {1'b1, 1'b1, (sa < 0) ? 16'h8000 : 16'h7FFF};
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        raw = (ma * (longint'(1) << (F + RND))) / mb;
        q   = (RND != 0) ? (raw + 1) / 2 : raw;
        if (!neg && q > 32767) return {1'b1, 1'b0, 16'h7FFF};
        if (neg && q > 32768)  return {1'b1, 1'b0, 16'h8000};
        v = neg ? -q : q;
        return {1'b0, 1'b0, 16'(v)};
    endfunction

    bit          m_act;
    int          m_k, m_L;
    logic        m_busy, m_done, m_ovf, m_dz, p_ovf, p_dz;
    logic [15:0] m_q, p_q;

    initial begin
        m_act = 0; m_k = 0; m_L = 0;
        m_busy = 0; m_done = 0; m_q = '0; m_ovf = 0; m_dz = 0;
        p_q = '0; p_ovf = 0; p_dz = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_act = 0; m_busy = 0; m_done = 0; m_q = '0; m_ovf = 0; m_dz = 0;
            end else begin
                m_done = 0;
                if (m_act) begin
                    m_k++;
                    if (m_k == m_L - 1) begin
                        m_act = 0; m_busy = 0; m_done = 1;
                        m_q = p_q; m_ovf = p_ovf; m_dz = p_dz;
                    end
                end else if (dif.start) begin
                    m_act = 1; m_busy = 1; m_k = 0;
                    {p_ovf, p_dz, p_q} = model(dif.dividend, dif.divisor);
                    m_L = (dif.divisor == '0) ? 2 : (W + F + RND + 2);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_vec++;
                if ({dif.busy, dif.done, dif.o_quotient, dif.overflow_flag, dif.div_zero} !==
                    {m_busy, m_done, m_q, m_ovf, m_dz}) begin
                    n_miss++;
                    $display("FAIL cycle t=%0t busy/done/q/ovf/dz got %b/%b/%h/%b/%b required %b/%b/%h/%b/%b",
                             $time, dif.busy, dif.done, dif.o_quotient, dif.overflow_flag, dif.div_zero,
                             m_busy, m_done, m_q, m_ovf, m_dz);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // Called at a negedge after acceptance edge E0+k0; returns edges from E0 (inclusive) to the done edge.
    task automatic wait_done(input int k0, output int lat);
        lat = -1;
        for (int k = k0; k < 60; k++) begin
            if (dif.done) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            n_vec++; n_miss++;
            $display("FAIL done_timeout: got no done required done within 60 cycles");
        end
    endtask

    // Called at a negedge with the DUT idle (or showing done); leaves the bench at the done negedge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
        @(negedge clk);
        dif.start = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 16'($urandom);
        wait_done(0, lat);
    endtask

    typedef struct {
        logic [15:0] a, b, q;
        logic        ovf, dz;
    } vec_t;
    vec_t dir[14];

    initial begin
        int lat, nl;
        bit seen;
        logic [15:0] ra, rb;
        nl = (RND != 0) ? 27 : 26;
        dir[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
`ifdef DIV_ROUND_EN
        dir[1]  = '{16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0};
        dir[2]  = '{16'h0001, 16'h0200, 16'h0001, 1'b0, 1'b0};
        dir[3]  = '{16'hFFFF, 16'h0200, 16'hFFFF, 1'b0, 1'b0};
`else
        dir[1]  = '{16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0};
        dir[2]  = '{16'h0001, 16'h0200, 16'h0000, 1'b0, 1'b0};
        dir[3]  = '{16'hFFFF, 16'h0200, 16'h0000, 1'b0, 1'b0};
`endif
        dir[4]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
        dir[5]  = '{16'h0300, 16'hFE00, 16'hFE80, 1'b0, 1'b0};
        dir[6]  = '{16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0};
        dir[7]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
        dir[8]  = '{16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0};
        dir[9]  = '{16'h8000, 16'h00FF, 16'h8000, 1'b1, 1'b0};
        dir[10] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
        dir[11] = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1};
        dir[12] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
        dir[13] = '{16'h0000, 16'hFE00, 16'h0000, 1'b0, 1'b0};

        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_q", 32'(dif.o_quotient), 32'h0);
        check("reset_flags", {29'd0, dif.busy, dif.done, dif.overflow_flag | dif.div_zero}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (dir[i]) begin
            check("model_pin", 32'(model(dir[i].a, dir[i].b)), 32'({dir[i].ovf, dir[i].dz, dir[i].q}));
            do_op(dir[i].a, dir[i].b, lat);
            check("dir_q", 32'(dif.o_quotient), 32'(dir[i].q));
            check("dir_flags", {30'd0, dif.overflow_flag, dif.div_zero}, {30'd0, dir[i].ovf, dir[i].dz});
            check("dir_latency", 32'(lat), 32'((dir[i].b == '0) ? 2 : nl));
        end

        // A start while busy must be dropped without disturbing the running division.
        dif.start = 1'b1; dif.dividend = 16'h0300; dif.divisor = 16'h0200;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (4) @(negedge clk);
        dif.start = 1'b1; dif.dividend = 16'h7F00; dif.divisor = 16'h0001;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(5, lat);
        check("busy_start_q", 32'(dif.o_quotient), 32'h0180);
        check("busy_start_latency", 32'(lat), 32'(nl));
        @(negedge clk);
        check("busy_start_not_queued", {31'd0, dif.busy}, 32'h0);

        // Reset mid-division aborts it: outputs clear and no done follows.
        dif.start = 1'b1; dif.dividend = 16'h7F00; dif.divisor = 16'h0080;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_q", 32'(dif.o_quotient), 32'h0);
        check("abort_flags", {29'd0, dif.busy, dif.done, dif.overflow_flag | dif.div_zero}, 32'h0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (dif.done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'h0);
        do_op(16'h0300, 16'h0200, lat);
        check("fresh_q", 32'(dif.o_quotient), 32'h0180);
        check("fresh_latency", 32'(lat), 32'(nl));

        for (int n = 0; n < 150; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 16'h0000;
                1: rb = 16'($urandom_range(1, 255));
                2: rb = 16'hFF00 | 16'($urandom_range(0, 255));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) ra = 16'h8000;
            do_op(ra, rb, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
